// File: rtl/int_bus_pkg.sv
// Shared execution-engine bus constants: module selects, opcodes and the integer ALU state type.
package int_bus_pkg;
  localparam logic [3:0] MainMemEn    = 4'd0;
  localparam logic [3:0] InstrMemEn   = 4'd1;
  localparam logic [3:0] MatrixAluEn  = 4'd2;
  localparam logic [3:0] IntegerAluEn = 4'd3;
  localparam logic [3:0] RegisterEn   = 4'd4;
  localparam logic [3:0] ExecuteEn    = 4'd5;

  localparam logic [7:0] IntAdd  = 8'h10;
  localparam logic [7:0] IntSub  = 8'h11;
  localparam logic [7:0] IntMult = 8'h12;
  localparam logic [7:0] IntDiv  = 8'h13;
  localparam logic [7:0] STOP    = 8'hFF;

  typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN} int_alu_state_t;
endpackage

// File: rtl/int_alu_responder_if.sv
// Execution-engine bus as seen by one responder slot.
interface int_alu_responder_if #(parameter int BUS_W = 256);
  logic [15:0]      address;
  logic [7:0]       opcode;
  logic             nRead;
  logic             nWrite;
  logic [BUS_W-1:0] ExeDataOut;
  logic [BUS_W-1:0] IntDataOut;
  logic             IntBusy;
  logic             IntDone;
  logic             DivByZero;
  logic             ErrOp;

  modport master (output address, opcode, nRead, nWrite, ExeDataOut,
                  input  IntDataOut, IntBusy, IntDone, DivByZero, ErrOp);
  modport slave  (input  address, opcode, nRead, nWrite, ExeDataOut,
                  output IntDataOut, IntBusy, IntDone, DivByZero, ErrOp);
endinterface

// File: rtl/int_divider_seq.sv
// Unsigned restoring divider, one quotient bit per cycle; remainder is kept internally only.
module int_divider_seq #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem, quo, b_q, rem_nxt, quo_nxt;
  logic [IW-1:0]    iter;
  logic             run, ok;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] diff;
  logic             unused_ok;

  always_comb begin
    partial = {rem, quo[WIDTH-1]};
    diff    = {1'b0, partial} - {2'b00, b_q};
    ok      = !diff[WIDTH+1];
    rem_nxt = ok ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ok};
  end

  assign busy      = run;
  assign done      = run && (iter == IW'(WIDTH-1));
  assign quotient  = quo_nxt;
  assign unused_ok = diff[WIDTH];

  // A zero divisor jumps straight to the last step with quo all-ones, so every
  // bit shifted in is 1 and the result is all-ones after a single cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      run  <= 1'b0;
      rem  <= '0;
      quo  <= '0;
      b_q  <= '0;
      iter <= '0;
    end else if (start) begin
      run <= 1'b1;
      rem <= '0;
      b_q <= b;
      if (b == '0) begin
        quo  <= '1;
        iter <= IW'(WIDTH-1);
      end else begin
        quo  <= a;
        iter <= '0;
      end
    end else if (run) begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      iter <= iter + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/int_alu_responder.sv
// Integer ALU bus responder: decodes the write strobe, runs add/sub/mult in one cycle
// or a sequential divide, and holds the last result on IntDataOut.
module int_alu_responder
  import int_bus_pkg::*;
#(
  parameter int         WIDTH  = 64,
  parameter int         BUS_W  = 256,
  parameter logic [3:0] SEL_ID = IntegerAluEn
) (
  input logic              Clk,
  input logic              nReset,
  int_alu_responder_if.slave bus
);
  int_alu_state_t   state;
  logic             wr, wr_q, start, div_start, div_busy, div_done;
  logic [WIDTH-1:0] src1, src2, a_q, b_q, exec_res, div_quo, result;
  logic [7:0]       op_q;
  logic             busy, done, dbz, err;
  logic             unused_ok;

  assign wr        = !bus.nWrite && (bus.address[15:12] == SEL_ID);
  assign start     = wr && !wr_q && (state == IDLE);
  assign src1      = bus.ExeDataOut[WIDTH-1:0];
  assign src2      = bus.ExeDataOut[2*WIDTH-1:WIDTH];
  assign div_start = start && (bus.opcode == IntDiv);
  assign unused_ok = ^{bus.nRead, bus.address[11:0], bus.ExeDataOut[BUS_W-1:2*WIDTH], div_busy};

  int_divider_seq #(.WIDTH(WIDTH)) u_div (
    .Clk      (Clk),
    .nReset   (nReset),
    .start    (div_start),
    .a        (src1),
    .b        (src2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    exec_res = '0;
    case (op_q)
      IntAdd:  exec_res = a_q + b_q;
      IntSub:  exec_res = a_q - b_q;
      IntMult: exec_res = a_q * b_q;
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      err    <= 1'b0;
    end else begin
      wr_q <= wr;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (bus.opcode)
            IntAdd, IntSub, IntMult: begin
              a_q   <= src1;
              b_q   <= src2;
              op_q  <= bus.opcode;
              busy  <= 1'b1;
              dbz   <= 1'b0;
              state <= EXEC;
            end
            IntDiv: begin
              busy  <= 1'b1;
              dbz   <= (src2 == '0);
              state <= DIV_RUN;
            end
            default: err <= 1'b1;
          endcase
        end
        EXEC: begin
          result <= exec_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        DIV_RUN: if (div_done) begin
          result <= div_quo;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IntDataOut = {{(BUS_W-WIDTH){1'b0}}, result};
  assign bus.IntBusy    = busy;
  assign bus.IntDone    = done;
  assign bus.DivByZero  = dbz;
  assign bus.ErrOp      = err;
endmodule

// File: tb/tb_int_alu_responder.sv
// Directed plus randomized checks of int_alu_responder against an arithmetic reference model.
module tb_int_alu_responder;
  import int_bus_pkg::*;

  localparam int NONE = 1000;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  int_alu_responder_if #(.BUS_W(256)) bus();

  int_alu_responder #(.WIDTH(64), .BUS_W(256), .SEL_ID(IntegerAluEn)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus.slave)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;

  task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [7:0] op, input logic [63:0] x, input logic [63:0] y);
    case (op)
      IntAdd:  return x + y;
      IntSub:  return x - y;
      IntMult: return x * y;
      IntDiv:  return (y == 64'd0) ? {64{1'b1}} : x / y;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [255:0] ext(input logic [63:0] v);
    return {192'd0, v};
  endfunction

  // One write strobe held for `hold` cycles starting at the next edge (edge 0 = N);
  // optionally a second add write (100+23) is presented after edge `inj`.
  // Observes a bounded 71-cycle window on the falling edges.
  task automatic run_op(input logic [3:0] sel, input logic [7:0] op,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input int hold, input int inj,
                        output int lat, output int ndone, output int nbusy, output int nerr);
    bus.address    = {sel, 12'hABC};
    bus.opcode     = op;
    bus.ExeDataOut = {128'd0, s2, s1};
    bus.nWrite     = 1'b0;
    lat = -1; ndone = 0; nbusy = 0; nerr = 0;
    for (int e = 0; e <= 70; e++) begin
      @(posedge Clk); #1;
      if (e + 1 == hold) bus.nWrite = 1'b1;
      if (e == inj) begin
        bus.address    = {IntegerAluEn, 12'h000};
        bus.opcode     = IntAdd;
        bus.ExeDataOut = {128'd0, 64'd23, 64'd100};
        bus.nWrite     = 1'b0;
      end
      if (e == inj + 1) bus.nWrite = 1'b1;
      @(negedge Clk);
      if (bus.IntDone) begin
        if (lat < 0) lat = e;
        ndone++;
      end
      if (bus.IntBusy) nbusy++;
      if (bus.ErrOp) nerr++;
    end
  endtask

  initial begin
    int lat, nd, nb, ne, quiet_done, quiet_busy;
    logic [7:0]  op;
    logic [63:0] s1, s2;

    bus.address = '0; bus.opcode = '0; bus.nRead = 1'b1; bus.nWrite = 1'b1; bus.ExeDataOut = '0;

    #12;
    chkv("reset_data", bus.IntDataOut, 256'd0);
    chkb("reset_busy", bus.IntBusy, 1'b0);
    chkb("reset_done", bus.IntDone, 1'b0);
    chkb("reset_dbz",  bus.DivByZero, 1'b0);
    chkb("reset_err",  bus.ErrOp, 1'b0);
    @(negedge Clk); nReset = 1'b1;
    @(negedge Clk);

    run_op(IntegerAluEn, IntAdd, 64'd5, 64'd7, 1, NONE, lat, nd, nb, ne);
    chki("add_lat", lat, 1);
    chki("add_ndone", nd, 1);
    chki("add_nbusy", nb, 1);
    chkv("add_data", bus.IntDataOut, ext(64'd12));

    run_op(IntegerAluEn, IntSub, 64'd3, 64'd5, 1, NONE, lat, nd, nb, ne);
    chki("sub_lat", lat, 1);
    chkv("sub_data", bus.IntDataOut, ext(64'hFFFF_FFFF_FFFF_FFFE));

    run_op(IntegerAluEn, IntMult, 64'hFFFF_FFFF, 64'd2, 3, NONE, lat, nd, nb, ne);
    chki("mult_ndone", nd, 1);
    chkv("mult_data", bus.IntDataOut, ext(64'h1_FFFF_FFFE));

    run_op(IntegerAluEn, IntDiv, 64'd100, 64'd7, 1, NONE, lat, nd, nb, ne);
    chki("div_nbusy", nb, 64);
    chki("div_lat", lat, 64);
    chki("div_ndone", nd, 1);
    chkv("div_data", bus.IntDataOut, ext(64'd14));
    chkb("div_dbz", bus.DivByZero, 1'b0);

    run_op(IntegerAluEn, IntDiv, 64'd100, 64'd0, 1, NONE, lat, nd, nb, ne);
    chki("div0_lat", lat, 1);
    chkv("div0_data", bus.IntDataOut, ext({64{1'b1}}));
    chkb("div0_dbz", bus.DivByZero, 1'b1);

    run_op(IntegerAluEn, 8'h01, 64'd1, 64'd1, 1, NONE, lat, nd, nb, ne);
    chki("illegal_nerr", ne, 1);
    chki("illegal_ndone", nd, 0);
    chki("illegal_nbusy", nb, 0);
    chkv("illegal_data", bus.IntDataOut, ext({64{1'b1}}));

    run_op(MatrixAluEn, IntAdd, 64'd1, 64'd1, 1, NONE, lat, nd, nb, ne);
    chki("unsel_ndone", nd, 0);
    chki("unsel_nerr", ne, 0);

    run_op(IntegerAluEn, IntDiv, 64'd100, 64'd7, 1, 10, lat, nd, nb, ne);
    chki("busywr_ndone", nd, 1);
    chki("busywr_nerr", ne, 0);
    chkv("busywr_data", bus.IntDataOut, ext(64'd14));

    run_op(IntegerAluEn, IntAdd, 64'd5, 64'd7, 1, 1, lat, nd, nb, ne);
    chki("b2b_lat", lat, 1);
    chki("b2b_ndone", nd, 2);
    chkv("b2b_data", bus.IntDataOut, ext(64'd123));

    for (int i = 0; i < 10; i++) begin
      op = IntAdd + 8'($urandom_range(0, 3));
      s1 = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       s2 = 64'd0;
        1:       s2 = 64'($urandom_range(1, 1000));
        default: s2 = {$urandom, $urandom};
      endcase
      run_op(IntegerAluEn, op, s1, s2, 1, NONE, lat, nd, nb, ne);
      chki($sformatf("rand%0d_lat", i), lat, (op == IntDiv && s2 != 0) ? 64 : 1);
      chki($sformatf("rand%0d_ndone", i), nd, 1);
      chkv($sformatf("rand%0d_data", i), bus.IntDataOut, ext(model(op, s1, s2)));
      chkb($sformatf("rand%0d_dbz", i), bus.DivByZero, (op == IntDiv && s2 == 0));
    end

    // Abort a divide partway through with an asynchronous reset.
    run_op(IntegerAluEn, IntAdd, 64'd5, 64'd7, 1, NONE, lat, nd, nb, ne);
    bus.address = {IntegerAluEn, 12'h0}; bus.opcode = IntDiv;
    bus.ExeDataOut = {128'd0, 64'd7, 64'd100}; bus.nWrite = 1'b0;
    @(posedge Clk); #1; bus.nWrite = 1'b1;
    repeat (20) @(posedge Clk);
    #2;
    chkb("abort_busy_before", bus.IntBusy, 1'b1);
    nReset = 1'b0;
    #1;
    chkv("abort_data", bus.IntDataOut, 256'd0);
    chkb("abort_busy", bus.IntBusy, 1'b0);
    chkb("abort_done", bus.IntDone, 1'b0);
    chkb("abort_dbz", bus.DivByZero, 1'b0);
    chkb("abort_err", bus.ErrOp, 1'b0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    quiet_done = 0; quiet_busy = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge Clk);
      if (bus.IntDone) quiet_done++;
      if (bus.IntBusy) quiet_busy++;
    end
    chki("abort_no_done", quiet_done, 0);
    chki("abort_no_busy", quiet_busy, 0);
    chkv("abort_data_held", bus.IntDataOut, 256'd0);

    run_op(IntegerAluEn, IntSub, 64'd10, 64'd4, 1, NONE, lat, nd, nb, ne);
    chki("post_reset_lat", lat, 1);
    chkv("post_reset_data", bus.IntDataOut, ext(64'd6));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
